// File: rtl/ctrl_types_pkg.sv
// rtl/ctrl_types_pkg.sv - operation and controller state encodings
// Constants and enums only; no ports.
package ctrl_types_pkg;
  // Three bits so that encodings 4..7 exist and are treated as unknown.
  localparam int OP_WIDTH = 3;

  typedef enum logic [OP_WIDTH-1:0] {
    NOOP   = 3'd0,
    READ   = 3'd1,
    UPSERT = 3'd2,
    DELETE = 3'd3
  } operation_e;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEARCH   = 3'd1,
    EXEC     = 3'd2,
    RESPOND  = 3'd3,
    WAIT_CLR = 3'd4
  } ctrl_state_e;
endpackage

// File: rtl/if_types_pkg.sv
// rtl/if_types_pkg.sv - key/value field widths of the OBI cache interface
// Constants only; no ports.
package if_types_pkg;
  localparam int KEY_WIDTH   = 32;
  localparam int VALUE_WIDTH = 64;
endpackage

// File: rtl/cache_entry_store.sv
// rtl/cache_entry_store.sv - flop-based key/value slot array with occupancy count
// Ports:
//   clk, rst            clock, asynchronous active-high reset (valid bits and count only)
//   i_rd_idx            combinational read address
//   o_rd_valid/key/value  slot contents at i_rd_idx
//   i_wr_en, i_wr_idx, i_wr_key, i_wr_value  write key/value and set valid
//   i_clr_en, i_clr_idx clear the valid bit of one slot (key/value untouched)
//   o_occupancy         number of valid slots
module cache_entry_store
  import if_types_pkg::*;
#(
  parameter int NUM_ENTRIES = 8,
  localparam int IDX_W = $clog2(NUM_ENTRIES),
  localparam int OCC_W = $clog2(NUM_ENTRIES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [IDX_W-1:0]       i_rd_idx,
  output logic                   o_rd_valid,
  output logic [KEY_WIDTH-1:0]   o_rd_key,
  output logic [VALUE_WIDTH-1:0] o_rd_value,
  input  logic                   i_wr_en,
  input  logic [IDX_W-1:0]       i_wr_idx,
  input  logic [KEY_WIDTH-1:0]   i_wr_key,
  input  logic [VALUE_WIDTH-1:0] i_wr_value,
  input  logic                   i_clr_en,
  input  logic [IDX_W-1:0]       i_clr_idx,
  output logic [OCC_W-1:0]       o_occupancy
);

  logic [NUM_ENTRIES-1:0] r_valid;
  logic [KEY_WIDTH-1:0]   r_key   [NUM_ENTRIES];
  logic [VALUE_WIDTH-1:0] r_value [NUM_ENTRIES];
  logic [OCC_W-1:0]       r_occ;

  assign o_rd_valid  = r_valid[i_rd_idx];
  assign o_rd_key    = r_key[i_rd_idx];
  assign o_rd_value  = r_value[i_rd_idx];
  assign o_occupancy = r_occ;

  // Occupancy tracks valid-bit transitions only: rewriting an already valid
  // slot (overwrite) or clearing an empty one leaves the count alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_occ   <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= 1'b1;
      if (!r_valid[i_wr_idx]) r_occ <= r_occ + OCC_W'(1);
    end else if (i_clr_en) begin
      r_valid[i_clr_idx] <= 1'b0;
      if (r_valid[i_clr_idx]) r_occ <= r_occ - OCC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_key[i_wr_idx]   <= i_wr_key;
      r_value[i_wr_idx] <= i_wr_value;
    end
  end

endmodule

// File: rtl/kv_cache_controller.sv
// rtl/kv_cache_controller.sv - linear-scan key/value controller (READ/UPSERT/DELETE)
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   operation_in        requested operation, NOOP = no request
//   key_in, value_in    request key and UPSERT data, sampled only in IDLE
//   ready_out           one-cycle result pulse (RESPOND)
//   op_succ_out         success flag, updated at the end of EXEC
//   value_out           READ data, updated at the end of EXEC
//   occupancy           number of valid entries
//   busy                high whenever the FSM is not in IDLE
module kv_cache_controller
  import ctrl_types_pkg::*;
  import if_types_pkg::*;
#(
  parameter int NUM_ENTRIES = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  operation_e                         operation_in,
  input  logic [KEY_WIDTH-1:0]               key_in,
  input  logic [VALUE_WIDTH-1:0]             value_in,
  output logic                               ready_out,
  output logic                               op_succ_out,
  output logic [VALUE_WIDTH-1:0]             value_out,
  output logic [$clog2(NUM_ENTRIES+1)-1:0]   occupancy,
  output logic                               busy
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  ctrl_state_e            r_state, w_state_nxt;
  logic [IDX_W-1:0]       r_idx;
  operation_e             r_op;
  logic [KEY_WIDTH-1:0]   r_key;
  logic [VALUE_WIDTH-1:0] r_value;
  logic                   r_hit, r_free;
  logic [IDX_W-1:0]       r_hit_idx, r_free_idx;
  logic                   r_succ;
  logic [VALUE_WIDTH-1:0] r_value_out;

  logic [IDX_W-1:0]       w_rd_idx;
  logic                   w_rd_valid;
  logic [KEY_WIDTH-1:0]   w_rd_key;
  logic [VALUE_WIDTH-1:0] w_rd_value;
  logic                   w_wr_en, w_clr_en;
  logic [IDX_W-1:0]       w_wr_idx;
  logic                   w_exec_succ;
  logic [VALUE_WIDTH-1:0] w_exec_value;

  // The scan drives the read port from the counter; in EXEC it is pointed at
  // the recorded hit so READ can return the stored value.
  assign w_rd_idx = (r_state == EXEC) ? r_hit_idx : r_idx;

  cache_entry_store #(.NUM_ENTRIES(NUM_ENTRIES)) u_store (
    .clk         (clk),
    .rst         (rst),
    .i_rd_idx    (w_rd_idx),
    .o_rd_valid  (w_rd_valid),
    .o_rd_key    (w_rd_key),
    .o_rd_value  (w_rd_value),
    .i_wr_en     (w_wr_en),
    .i_wr_idx    (w_wr_idx),
    .i_wr_key    (r_key),
    .i_wr_value  (r_value),
    .i_clr_en    (w_clr_en),
    .i_clr_idx   (r_hit_idx),
    .o_occupancy (occupancy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    ready_out   = 1'b0;
    busy        = (r_state != IDLE);
    case (r_state)
      IDLE:     if (operation_in != NOOP) w_state_nxt = SEARCH;
      SEARCH:   if (r_idx == LAST_IDX) w_state_nxt = EXEC;
      EXEC:     w_state_nxt = RESPOND;
      RESPOND: begin
        ready_out   = 1'b1;
        w_state_nxt = WAIT_CLR;
      end
      // Waiting for NOOP keeps a request held by upstream from re-executing.
      WAIT_CLR: if (operation_in == NOOP) w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_wr_en      = 1'b0;
    w_wr_idx     = r_hit_idx;
    w_clr_en     = 1'b0;
    w_exec_succ  = 1'b0;
    w_exec_value = '0;
    if (r_state == EXEC) begin
      case (r_op)
        READ: if (r_hit) begin
          w_exec_succ  = 1'b1;
          w_exec_value = w_rd_value;
        end
        UPSERT: if (r_hit) begin
          w_wr_en     = 1'b1;
          w_exec_succ = 1'b1;
        end else if (r_free) begin
          w_wr_en     = 1'b1;
          w_wr_idx    = r_free_idx;
          w_exec_succ = 1'b1;
        end
        DELETE: if (r_hit) begin
          w_clr_en    = 1'b1;
          w_exec_succ = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx       <= '0;
      r_op        <= NOOP;
      r_key       <= '0;
      r_value     <= '0;
      r_hit       <= 1'b0;
      r_free      <= 1'b0;
      r_hit_idx   <= '0;
      r_free_idx  <= '0;
      r_succ      <= 1'b0;
      r_value_out <= '0;
    end else begin
      case (r_state)
        IDLE: if (operation_in != NOOP) begin
          r_op    <= operation_in;
          r_key   <= key_in;
          r_value <= value_in;
          r_hit   <= 1'b0;
          r_free  <= 1'b0;
          r_idx   <= '0;
        end
        SEARCH: begin
          if (w_rd_valid && (w_rd_key == r_key)) begin
            r_hit     <= 1'b1;
            r_hit_idx <= r_idx;
          end
          // First empty slot seen wins, giving the lowest free index.
          if (!w_rd_valid && !r_free) begin
            r_free     <= 1'b1;
            r_free_idx <= r_idx;
          end
          if (r_idx != LAST_IDX) r_idx <= r_idx + IDX_W'(1);
        end
        EXEC: begin
          r_succ      <= w_exec_succ;
          r_value_out <= w_exec_value;
        end
        default: ;
      endcase
    end
  end

  assign op_succ_out = r_succ;
  assign value_out   = r_value_out;

endmodule

// File: doc/kv_cache_controller.md
# kv_cache_controller

Key-value store controller directly downstream of the OBI cache interface. Consumes its decoded operation/key/value request and returns a ready pulse, a success flag and read data. Stores up to NUM_ENTRIES key/value pairs in flop-based storage and executes READ, UPSERT and DELETE with a deterministic linear scan.

## Interface
- NUM_ENTRIES, 8: number of key/value slots; must be ≥2.
- clk  in  1  clock; all flops rise on posedge.
- rst  in  1  asynchronous, active-high reset.
- operation_in  in  ctrl_types_pkg::operation_e  requested operation; NOOP = no request.
- key_in  in  if_types_pkg::KEY_WIDTH  request key.
- value_in  in  if_types_pkg::VALUE_WIDTH  write data for UPSERT.
- ready_out  out  1  one-cycle pulse: the result is valid.
- op_succ_out  out  1  operation succeeded; valid while ready_out=1, held afterwards.
- value_out  out  if_types_pkg::VALUE_WIDTH  READ data; valid while ready_out=1, held until the next request is captured.
- occupancy  out  $clog2(NUM_ENTRIES+1)  number of valid entries.
- busy  out  1  high in every state except IDLE.

## Operation
- **States:** IDLE, SEARCH, EXEC, RESPOND, WAIT_CLR.
- **IDLE:** on operation_in != NOOP, latch op, key and value, clear the hit and free flags, set idx←0, then go to SEARCH.
- **SEARCH:**
  - One entry per cycle, idx 0..NUM_ENTRIES-1.
  - Record the hit index on valid && key match; there is at most one.
  - Record the lowest free index among entries that are not valid.
  - Always scans all entries; no early exit.
  - After idx = NUM_ENTRIES-1, go to EXEC. idx never wraps.
- **EXEC:** perform the action below, register the result, go to RESPOND.
  - READ, hit: value_out←stored value, succ=1.
  - READ, miss: value_out←0, succ=0.
  - UPSERT, hit: overwrite that entry's value, succ=1.
  - UPSERT, miss with a free slot: write key/value/valid into the lowest free slot, succ=1.
  - UPSERT, miss with storage full: no write, succ=0.
  - DELETE, hit: clear the valid bit, succ=1. Key and value bits stay unchanged.
  - DELETE, miss: succ=0.
  - Unknown encoding: no state change, succ=0, value_out←0.
  - For non-READ operations, value_out←0.
- **RESPOND:** ready_out=1 for exactly this cycle, then go to WAIT_CLR.
- **WAIT_CLR:** stay until operation_in == NOOP, then go to IDLE.
  - The upstream interface keeps presenting the finished request for at least one cycle after ready.
  - A request is never re-executed.
- **occupancy:** increments on a successful UPSERT insert, decrements on a successful DELETE, unchanged otherwise. It is registered and updates at the end of EXEC.
- **Key 0:** a legal key; it has no special meaning.
- **Stability:** inputs are sampled only in IDLE. Changes to key_in or value_in after capture are ignored.

## Timing
- **Latency:** request sampled at edge 0; ready_out is high in cycle NUM_ENTRIES+2 after that edge (10 cycles at the default).
- **Outputs are registered:**
  - ready_out is a Moore output of RESPOND.
  - op_succ_out and value_out change only at the end of EXEC.
- **Throughput:** minimum spacing between request captures is NUM_ENTRIES+4 cycles.
- **Reset values:**
  - state=IDLE and idx=0.
  - All valid bits=0.
  - ready_out=0, op_succ_out=0, value_out=0, occupancy=0, busy=0.
  - Key/value storage needs no reset.
- **Reset mid-operation:** the operation is abandoned and no write occurs. After release, the block returns to IDLE and treats a still-present operation_in as a new request.
- **Simultaneous events:** a write in EXEC and a scan of the same entry cannot overlap, because scan and write are in disjoint states.

## Structure
- **ctrl_types_pkg:**
  - Holds operation_e with NOOP=0, READ=1, UPSERT=2, DELETE=3, width OP_WIDTH.
  - Add ctrl_state_e for this block's states.
- **if_types_pkg:** KEY_WIDTH and VALUE_WIDTH; no new constants.
- **cache_entry_store sub-module:**
  - NUM_ENTRIES × {valid, key, value}.
  - Combinational read port at idx.
  - One synchronous write port with write-entry and clear-valid controls.
  - Exposes occupancy.
- The FSM, scan counter and result registers stay in kv_cache_controller.

## Test plan
- **Reset:** assert rst mid-SEARCH → all outputs 0. A subsequent READ of any key returns succ=0, value_out=0.
- **Insert and read back:** UPSERT key 0x12 with value 0xDEADBEEF_CAFEF00D, then READ 0x12. Required:
  - The UPSERT gives ready at cycle 10 with succ=1.
  - occupancy=1.
  - The READ returns succ=1 and that value.
- **Overwrite:** UPSERT 0x12 with value 5, then READ 0x12. Required: value_out=5, occupancy stays 1.
- **Capacity:** UPSERT keys 1..8 all give succ=1. UPSERT key 9 gives succ=0 with occupancy=8. DELETE key 3 gives succ=1 with occupancy=7. UPSERT key 9 then lands in slot 2 (lowest free) with succ=1.
- **Miss cases:** DELETE of a never-inserted key → succ=0, occupancy unchanged. Unknown opcode → succ=0 and no state change.
- **Request held:** hold operation_in=READ for 5 cycles after ready, then NOOP. Required: exactly one ready pulse and busy high until the cycle after NOOP is seen.
